// File: rtl/multicycle_control.sv
// Multicycle ARM main sequencer: instruction-phase FSM, NZCV flags, condition check, datapath controls.
// Optional MC_CMP_EN: decode cmd 1010 (CMP) as a flag-setting subtract with no register write.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] RegSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] state,
  output logic [3:0] flags
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t     cur, nxt;
  logic [1:0] dp_alu;
  logic       dp_writes;
  logic [1:0] flag_w;
  logic       cond_ex;
  logic       n, z, c, v;

  assign state  = cur;
  assign ImmSrc = Op;
  assign {n, z, c, v} = flags;

  always_ff @(posedge clk) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:    nxt = DECODE;
      DECODE: begin
        case (Op)
          2'b01:   nxt = MEMADR;
          2'b00:   nxt = Funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   nxt = BRANCH;
          default: nxt = FETCH;
        endcase
      end
      MEMADR:   nxt = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  nxt = MEMWB;
      EXECUTER: nxt = ALUWB;
      EXECUTEI: nxt = ALUWB;
      default:  nxt = FETCH;
    endcase
  end

  // flag_w[1] selects N,Z; flag_w[0] selects C,V
  always_comb begin
    dp_alu    = 2'b00;
    dp_writes = 1'b0;
    flag_w    = 2'b00;
    case (Funct[4:1])
      4'b0100: begin dp_alu = 2'b00; dp_writes = 1'b1; flag_w = {2{Funct[0]}}; end
      4'b0010: begin dp_alu = 2'b01; dp_writes = 1'b1; flag_w = {2{Funct[0]}}; end
      4'b0000: begin dp_alu = 2'b10; dp_writes = 1'b1; flag_w = {Funct[0], 1'b0}; end
      4'b1100: begin dp_alu = 2'b11; dp_writes = 1'b1; flag_w = {Funct[0], 1'b0}; end
`ifdef MC_CMP_EN
      4'b1010: begin dp_alu = 2'b01; dp_writes = 1'b0; flag_w = 2'b11; end
`else
`endif
      default: ;
    endcase
  end

  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= 4'b0000;
    end else if ((cur == EXECUTER || cur == EXECUTEI) && cond_ex) begin
      if (flag_w[1]) flags[3:2] <= ALUFlags[3:2];
      if (flag_w[0]) flags[1:0] <= ALUFlags[1:0];
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    RegSrc     = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    case (cur)
      FETCH: begin
        IRWrite = 1'b1; PCWrite = 1'b1;
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_ex;
        PCWrite   = cond_ex && (Rd == 4'd15);
      end
      MEMWRITE: begin
        AdrSrc = 1'b1; RegSrc = 2'b10; MemWrite = cond_ex;
      end
      EXECUTER: ALUControl = dp_alu;
      EXECUTEI: begin ALUSrcB = 2'b01; ALUControl = dp_alu; end
      ALUWB: begin
        RegWrite = cond_ex & dp_writes;
        PCWrite  = cond_ex & dp_writes & (Rd == 4'd15);
      end
      BRANCH: begin
        RegSrc = 2'b01; ALUSrcB = 2'b01; ResultSrc = 2'b10; PCWrite = cond_ex;
      end
      default: ;
    endcase
    // Reset overrides every datapath write so an abandoned instruction leaves no trace
    if (reset) begin
      PCWrite = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0; MemWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks ADDS, B, LDR, STR, Op=11, CMP and reset cases.
module tb_multicycle_control;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
                         S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                         S_ALUWB = 4'd8, S_BRANCH = 4'd9;
`ifdef MC_CMP_EN
  localparam logic [3:0] CMP_ALU = 4'd1, CMP_FLAGS = 4'b1000;
`else
  localparam logic [3:0] CMP_ALU = 4'd0, CMP_FLAGS = 4'b0000;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
  logic [1:0] RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
  logic [3:0] state, flags;
  logic [3:0] strobes;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  assign strobes = {PCWrite, IRWrite, RegWrite, MemWrite};

  multicycle_control dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .state(state), .flags(flags)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample mid-cycle, away from the rising edge
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; Cond = 4'b1110; Op = 2'b00; Funct = 6'b000000; Rd = 4'd0; ALUFlags = 4'b0000;
    repeat (3) begin
      cyc();
      chk("rst_strobes", strobes, 4'b0000);
    end
    chk("rst_state", state, S_FETCH);
    chk("rst_flags", flags, 4'b0000);

    // ADDS R1,R2,#5
    Op = 2'b00; Funct = 6'b101001; Rd = 4'd1;
    reset = 1'b0; #1;
    chk("fetch1_strobes", strobes, 4'b1100);
    chk("fetch1_srcb", {2'b00, ALUSrcB}, 4'd2);
    chk("fetch1_srca", {3'b000, ALUSrcA}, 4'd1);
    chk("fetch1_state", state, S_FETCH);
    cyc(); chk("adds_decode", state, S_DECODE);
    chk("adds_decode_strobes", strobes, 4'b0000);
    cyc(); chk("adds_execi", state, S_EXECI);
    chk("adds_alu", {2'b00, ALUControl}, 4'd0);
    chk("adds_srcb", {2'b00, ALUSrcB}, 4'd1);
    ALUFlags = 4'b0100;
    cyc(); chk("adds_aluwb", state, S_ALUWB);
    chk("adds_wb_strobes", strobes, 4'b0010);
    chk("adds_wb_ressrc", {2'b00, ResultSrc}, 4'd0);
    chk("adds_flags", flags, 4'b0100);
    ALUFlags = 4'b0000;

    // BNE with Z=1: not taken
    Cond = 4'b0001; Op = 2'b10; Rd = 4'd0;
    cyc(); chk("bne1_fetch", state, S_FETCH);
    chk("bne1_fetch_strobes", strobes, 4'b1100);
    cyc(); chk("bne1_decode", state, S_DECODE);
    cyc(); chk("bne1_branch", state, S_BRANCH);
    chk("bne1_strobes", strobes, 4'b0000);
    chk("bne1_regsrc", {2'b00, RegSrc}, 4'd1);

    // ADDS producing Z=0
    Cond = 4'b1110; Op = 2'b00; Funct = 6'b101001; Rd = 4'd2;
    cyc(); chk("adds2_fetch", state, S_FETCH);
    cyc(); cyc(); chk("adds2_execi", state, S_EXECI);
    cyc(); chk("adds2_flags", flags, 4'b0000);

    // BNE with Z=0: taken, three cycles
    Cond = 4'b0001; Op = 2'b10;
    cyc(); chk("bne2_fetch", state, S_FETCH);
    cyc(); cyc(); chk("bne2_branch", state, S_BRANCH);
    chk("bne2_strobes", strobes, 4'b1000);
    cyc(); chk("bne2_return", state, S_FETCH);

    // LDR R3
    Cond = 4'b1110; Op = 2'b01; Funct = 6'b011001; Rd = 4'd3;
    cyc(); chk("ldr_decode", state, S_DECODE);
    cyc(); chk("ldr_memadr", state, S_MEMADR);
    chk("ldr_memadr_src", {1'b0, ALUSrcA, ALUSrcB}, 4'b0001);
    cyc(); chk("ldr_memread", state, S_MEMREAD);
    chk("ldr_adrsrc", {3'b000, AdrSrc}, 4'd1);
    chk("ldr_memread_strobes", strobes, 4'b0000);
    cyc(); chk("ldr_memwb", state, S_MEMWB);
    chk("ldr_ressrc", {2'b00, ResultSrc}, 4'd1);
    chk("ldr_wb_strobes", strobes, 4'b0010);
    cyc(); chk("ldr_return", state, S_FETCH);

    // STREQ with Z=0: no memory write
    Cond = 4'b0000; Funct = 6'b011000; Rd = 4'd4;
    cyc(); cyc(); chk("str_memadr", state, S_MEMADR);
    cyc(); chk("str_memwrite", state, S_MEMWRITE);
    chk("str_strobes", strobes, 4'b0000);
    chk("str_adr_regsrc", {1'b0, AdrSrc, RegSrc}, 4'b0110);
    cyc(); chk("str_return", state, S_FETCH);

    // Op=11: two-cycle no-op
    Cond = 4'b1110; Op = 2'b11;
    cyc(); chk("op3_decode", state, S_DECODE);
    chk("op3_immsrc", {2'b00, ImmSrc}, 4'd3);
    cyc(); chk("op3_return", state, S_FETCH);
    chk("op3_fetch_strobes", strobes, 4'b1100);

    // LDR PC: result write also redirects PC
    Op = 2'b01; Funct = 6'b011001; Rd = 4'd15;
    cyc(); cyc(); cyc(); cyc(); chk("ldrpc_memwb", state, S_MEMWB);
    chk("ldrpc_strobes", strobes, 4'b1010);
    cyc(); chk("ldrpc_return", state, S_FETCH);

    // CMP (cmd 1010, S=1)
    Op = 2'b00; Funct = 6'b010101; Rd = 4'd0;
    cyc(); cyc(); chk("cmp_execr", state, S_EXECR);
    chk("cmp_alu", {2'b00, ALUControl}, CMP_ALU);
    chk("cmp_srcb", {2'b00, ALUSrcB}, 4'd0);
    ALUFlags = 4'b1000;
    cyc(); chk("cmp_aluwb", state, S_ALUWB);
    chk("cmp_strobes", strobes, 4'b0000);
    chk("cmp_flags", flags, CMP_FLAGS);
    ALUFlags = 4'b0000;

    // Reset in the middle of an LDR
    Op = 2'b01; Funct = 6'b011001; Rd = 4'd5;
    cyc(); chk("mid_fetch", state, S_FETCH);
    cyc(); cyc(); chk("mid_memadr", state, S_MEMADR);
    reset = 1'b1; #1;
    chk("mid_rst_strobes", strobes, 4'b0000);
    cyc(); chk("mid_rst_state", state, S_FETCH);
    chk("mid_rst_strobes2", strobes, 4'b0000);
    chk("mid_rst_flags", flags, 4'b0000);
    reset = 1'b0; #1;
    chk("mid_release_strobes", strobes, 4'b1100);
    cyc(); chk("mid_release_decode", state, S_DECODE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

- Main sequencer for the multicycle ARM processor.
- Owns the instruction-phase state machine, the NZCV flags register and condition evaluation.
- Drives every select and write-enable of the shared datapath: register file, extend, adder/ALU, muxes and the PC/IR/data flops.
- The single ALU and memory port are time-shared across FETCH/DECODE/EXECUTE/WB phases under its control.

## Interface
- (no parameters)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20] (I, cmd[3:0], S)
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  {N,Z,C,V} from ALU, same cycle
- PCWrite, IRWrite, RegWrite, MemWrite  out  1  datapath write strobes
- AdrSrc  out  1  0=PC, 1=ALUOut as memory address
- RegSrc  out  2  [0]=1 read R15 on ra1; [1]=1 read Rd on ra2
- ALUSrcA  out  1  0=register A, 1=PC
- ALUSrcB  out  2  00=WriteData reg, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ImmSrc  out  2  equals Op
- ALUControl  out  2  00 add, 01 sub, 10 and, 11 orr

## Operation
- States:
  - FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, add; -> DECODE.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, add. Exits on Op/Funct:
    - Op=01 -> MEMADR
    - Op=00 & Funct[5]=0 -> EXECUTER
    - Op=00 & Funct[5]=1 -> EXECUTEI
    - Op=10 -> BRANCH
    - Op=11 -> FETCH, no side effects
  - MEMADR: ALUSrcA=0, ALUSrcB=01, add; Funct[0]=1 -> MEMREAD, else MEMWRITE.
  - MEMREAD: AdrSrc=1 -> MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=CondEx -> FETCH.
  - MEMWRITE: AdrSrc=1, RegSrc[1]=1, MemWrite=CondEx -> FETCH.
  - EXECUTER / EXECUTEI: ALUSrcA=0, ALUSrcB=00 / 01, ALUControl from cmd -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=CondEx & writes -> FETCH.
  - BRANCH: RegSrc[0]=1, ALUSrcA=0, ALUSrcB=01, ResultSrc=10, add, PCWrite=CondEx -> FETCH.
- ALU decode (cmd): 0100 ADD->00, 0010 SUB->01, 0000 AND->10, 1100 ORR->11. Any other cmd: ALUControl=00, writes=0, FlagW=00.
- Flag update:
  - FlagW: S=1 with ADD/SUB -> {NZ,CV}; S=1 with AND/ORR -> NZ only.
  - Flags register loads the selected fields from ALUFlags at the clock edge ending EXECUTER/EXECUTEI, only if CondEx.
- CondEx: combinational from the flags register.
  - All ARM codes EQ..LE evaluated.
  - 1110 (AL) = 1; 1111 = 0.
- PC-target writes: RegWrite with Rd=15 in ALUWB/MEMWB also asserts PCWrite (gated by CondEx).
- Outputs not listed for a state are 0.

## Timing
- Moore outputs except CondEx-gated strobes, which are combinational from state plus flags.
- Latencies in cycles, FETCH..return: LDR 5, STR 4, DP 4, B 3, Op=11 2.
- Flag update from one instruction is visible to the CondEx of the next instruction (earliest use ≥2 cycles later).
- Reset:
  - Next state=FETCH; flags=0000.
  - While reset=1, PCWrite/IRWrite/RegWrite/MemWrite are forced 0.
  - Reset mid-instruction abandons it with no further writes.
  - First FETCH strobes occur in the cycle after reset deasserts.

## Configuration
- MC_CMP_EN defined: cmd 1010 (CMP) decodes as sub, FlagW={NZ,CV} regardless of S, and RegWrite=0 in ALUWB.
- MC_CMP_EN undefined: cmd 1010 is unsupported and treated as above (no write, no flag change).

## Test plan
- Reset held 3 cycles, then released: all strobes 0 during reset; cycle 1 after release FETCH (IRWrite=1, PCWrite=1, ALUSrcB=10), cycle 2 DECODE.
- ADDS R1,R2,#5 (Cond=1110, Funct=101001) with ALUFlags=0100: EXECUTEI ALUControl=00; ALUWB RegWrite=1; flags become 0100.
- Flags Z=1, then BNE (Cond=0001, Op=10): BRANCH PCWrite=0. Then flags Z=0: PCWrite=1 in BRANCH; 3-cycle instruction.
- LDR (Op=01, Funct[0]=1): states FETCH, DECODE, MEMADR, MEMREAD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1).
- STR with Cond=0000 and Z=0: MemWrite stays 0 through MEMWRITE; next state FETCH.
- MC_CMP_EN build, CMP (cmd 1010) with ALUFlags=1000: RegWrite=0 in ALUWB; flags become 1000. Without the macro: flags unchanged.
